// File: rtl/operand_fetch_if.sv
// Bundle of the request, register-bank and result signals around operand_fetch.
// The slave modport is the fetch unit; the master modport is everything around it.
interface operand_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  modport slave (
    input  in_valid, rs1, rs2, rd1, rd2, wb_we, wb_addr, wb_data, out_ready,
    output in_ready, a1, a2, out_valid, op1, op2
  );

  modport master (
    output in_valid, rs1, rs2, rd1, rd2, wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, a1, a2, out_valid, op1, op2
  );
endinterface

// File: rtl/operand_fetch.sv
// Two-cycle operand fetch: registered bank read plus write-port snooping so a
// result always reflects the newest architectural value of each source register.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_fetch_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t            state;
  state_t            state_next;
  logic              ready_c;
  logic              accept;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic              fwd1_valid;
  logic              fwd2_valid;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;

  // x0 is hard-wired, so a write to it is never a forwarding source.
  function automatic logic wb_hit(input logic we, input logic [ADDR_W-1:0] waddr,
                                  input logic [ADDR_W-1:0] idx);
    return we && (waddr == idx) && (idx != '0);
  endfunction

  function automatic logic [DATA_W-1:0] resolve(
    input logic [ADDR_W-1:0] idx,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic              fv,
    input logic [DATA_W-1:0] fd,
    input logic [DATA_W-1:0] rd
  );
    if (idx == '0)                 return '0;
    else if (wb_hit(we, waddr, idx)) return wdata;
    else if (fv)                   return fd;
    else                           return rd;
  endfunction

  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.in_valid) state_next = READ;
      end
      READ: state_next = HOLD;
      HOLD: begin
        if (bus.out_ready) begin
          ready_c    = 1'b1;
          state_next = bus.in_valid ? READ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = ready_c & ~rst;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.a1        = (state == READ) ? rs1_q : bus.rs1;
  assign bus.a2        = (state == READ) ? rs2_q : bus.rs2;
  assign bus.out_valid = (state == HOLD);
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;

  // Stage boundary: accept edge captures indices and any same-edge write,
  // READ edge resolves operands, HOLD keeps them coherent with later writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      fwd1_valid <= 1'b0;
      fwd2_valid <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rs1_q      <= bus.rs1;
        rs2_q      <= bus.rs2;
        fwd1_valid <= wb_hit(bus.wb_we, bus.wb_addr, bus.rs1);
        fwd2_valid <= wb_hit(bus.wb_we, bus.wb_addr, bus.rs2);
      end
      if (state == READ) begin
        op1_q <= resolve(rs1_q, bus.wb_we, bus.wb_addr, bus.wb_data, fwd1_valid, fwd1_data, bus.rd1);
        op2_q <= resolve(rs2_q, bus.wb_we, bus.wb_addr, bus.wb_data, fwd2_valid, fwd2_data, bus.rd2);
      end else if (state == HOLD && !bus.out_ready) begin
        if (wb_hit(bus.wb_we, bus.wb_addr, rs1_q)) op1_q <= bus.wb_data;
        if (wb_hit(bus.wb_we, bus.wb_addr, rs2_q)) op2_q <= bus.wb_data;
      end
    end
  end

  // Forward data is only consulted when its valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      fwd1_data <= bus.wb_data;
      fwd2_data <= bus.wb_data;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural registered-read register bank.
module tb_operand_fetch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  operand_fetch_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: registered read of the pre-write contents, write on the same edge.
  logic [31:0] bank [32];
  always @(posedge clk) begin
    bus.rd1 <= bank[bus.a1];
    bus.rd2 <= bank[bus.a2];
    if (bus.wb_we) bank[bus.wb_addr] <= bus.wb_data;
  end

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] init1;
    logic [31:0] init2;
    logic        acc_we;
    logic [4:0]  acc_addr;
    logic [31:0] acc_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bank_write(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_we   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    next_cycle();
    bus.wb_we   = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    bank_write(v.rs1, v.init1);
    bank_write(v.rs2, v.init2);
    bus.in_valid = 1'b1;
    bus.rs1      = v.rs1;
    bus.rs2      = v.rs2;
    bus.wb_we    = v.acc_we;
    bus.wb_addr  = v.acc_addr;
    bus.wb_data  = v.acc_data;
    @(negedge clk);
    check($sformatf("vec%0d in_ready", i), {31'b0, bus.in_ready}, 32'd1);
    next_cycle();
    bus.in_valid = 1'b0;
    bus.wb_we    = v.rd_we;
    bus.wb_addr  = v.rd_addr;
    bus.wb_data  = v.rd_data;
    @(negedge clk);
    check($sformatf("vec%0d read out_valid", i), {31'b0, bus.out_valid}, 32'd0);
    next_cycle();
    bus.wb_we = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d out_valid", i), {31'b0, bus.out_valid}, 32'd1);
    check($sformatf("vec%0d op1", i), bus.op1, v.exp1);
    check($sformatf("vec%0d op2", i), bus.op2, v.exp2);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //          rs1 rs2 init1        init2        acc we/addr/data        rd we/addr/data         exp1         exp2
    vecs[0] = '{5'd5, 5'd6, 32'h1234, 32'hABCD, 1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,    32'h1234, 32'hABCD};
    vecs[1] = '{5'd5, 5'd6, 32'h11,   32'h66,   1'b1, 5'd5,  32'h55,   1'b0, 5'd0, 32'h0,    32'h55,   32'h66};
    vecs[2] = '{5'd5, 5'd6, 32'h11,   32'h66,   1'b1, 5'd5,  32'h22,   1'b1, 5'd5, 32'h33,   32'h33,   32'h66};
    vecs[3] = '{5'd0, 5'd0, 32'hDEAD, 32'hDEAD, 1'b1, 5'd0,  32'hFFFF, 1'b1, 5'd0, 32'hEEEE, 32'h0,    32'h0};
    vecs[4] = '{5'd7, 5'd7, 32'h7777, 32'h7777, 1'b1, 5'd7,  32'h99,   1'b0, 5'd0, 32'h0,    32'h99,   32'h99};
    vecs[5] = '{5'd3, 5'd4, 32'h30,   32'h40,   1'b0, 5'd0,  32'h0,    1'b1, 5'd4, 32'h44,   32'h30,   32'h44};
    vecs[6] = '{5'd8, 5'd9, 32'h80,   32'h90,   1'b1, 5'd10, 32'h123,  1'b0, 5'd0, 32'h0,    32'h80,   32'h90};
    vecs[7] = '{5'd1, 5'd2, 32'h1,    32'h2,    1'b1, 5'd2,  32'h222,  1'b1, 5'd1, 32'h111,  32'h111,  32'h222};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.wb_we     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("reset out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("reset op1", bus.op1, 32'd0);
    check("reset op2", bus.op2, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    next_cycle();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Backpressure with a HOLD-time write to rs2
    bank_write(5'd5, 32'h1234);
    bank_write(5'd6, 32'hABCD);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.rs1       = 5'd5;
    bus.rs2       = 5'd6;
    next_cycle();
    bus.in_valid  = 1'b0;
    next_cycle();
    @(negedge clk);
    check("bp out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("bp op1", bus.op1, 32'h1234);
    check("bp op2", bus.op2, 32'hABCD);
    check("bp in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd6;
    bus.wb_data = 32'h77;
    next_cycle();
    bus.wb_we   = 1'b0;
    @(negedge clk);
    check("bp upd op2", bus.op2, 32'h77);
    check("bp upd op1", bus.op1, 32'h1234);
    check("bp upd out_valid", {31'b0, bus.out_valid}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("bp hold3 op2", bus.op2, 32'h77);
    check("bp hold3 out_valid", {31'b0, bus.out_valid}, 32'd1);

    // Back-to-back: release HOLD while presenting the next request
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.rs1       = 5'd6;
    bus.rs2       = 5'd5;
    #1;
    check("b2b in_ready", {31'b0, bus.in_ready}, 32'd1);
    next_cycle();
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("b2b read out_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("b2b out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("b2b op1", bus.op1, 32'h77);
    check("b2b op2", bus.op2, 32'h1234);
    next_cycle();
    @(negedge clk);
    check("b2b idle out_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();

    // Reset while in READ aborts the request
    bus.in_valid = 1'b1;
    bus.rs1      = 5'd1;
    bus.rs2      = 5'd2;
    next_cycle();
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check("rst-read in_ready", {31'b0, bus.in_ready}, 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst-read out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst-read in_ready after", {31'b0, bus.in_ready}, 32'd1);
    check("rst-read op1 cleared", bus.op1, 32'd0);
    bus.in_valid = 1'b1;
    bus.rs1      = 5'd1;
    bus.rs2      = 5'd2;
    next_cycle();
    bus.in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rst-read new out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("rst-read new op1", bus.op1, 32'h111);
    check("rst-read new op2", bus.op2, 32'h222);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The module SHALL have one clock and a synchronous active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 Ports: in_valid  in  1  request valid; in_ready  out  1  request accepted when both high at an edge; rs1, rs2  in  5 each  source register indices.
REQ-004 Ports: a1, a2  out  5 each  read addresses to the register bank; rd1, rd2  in  32 each  register bank read data, registered, valid one cycle after the address edge.
REQ-005 Ports: wb_we  in  1, wb_addr  in  5, wb_data  in  32  snoop of the register bank write port (same signals as the bank's write enable, write address and write data).
REQ-006 Ports: out_valid  out  1  operands valid; out_ready  in  1  consumer accepts; op1, op2  out  32 each  resolved operands.

Function
REQ-007 The FSM SHALL have three states: IDLE, READ and HOLD.
REQ-008 in_ready SHALL be 1 in IDLE, and in HOLD when out_ready=1; it SHALL be 0 otherwise.
REQ-009 Accepting a request (in_valid & in_ready) SHALL latch rs1/rs2 into rs1_q/rs2_q and move the FSM to READ.
REQ-010 In IDLE and HOLD, a1/a2 SHALL equal rs1/rs2 combinationally; in READ they SHALL equal rs1_q/rs2_q.
REQ-011 READ SHALL last exactly one cycle, then move to HOLD; out_valid SHALL be 1 only in HOLD.
REQ-012 Latency SHALL be 2 edges: accept at edge N, out_valid=1 after edge N+1.
REQ-013 In HOLD, out_ready=1 with in_valid=1 SHALL go to READ, giving back-to-back operation at one result every 2 cycles.
REQ-014 In HOLD, out_ready=1 with in_valid=0 SHALL go to IDLE; out_ready=0 SHALL stay in HOLD with op1/op2 stable, except as stated in REQ-018.
REQ-015 Accept-edge bypass: if wb_we=1 and wb_addr=rs1 at the accept edge, the module SHALL capture fwd1_valid=1 and fwd1_data=wb_data; otherwise fwd1_valid=0. rs2 SHALL be handled the same way.
REQ-016 At the edge ending READ, op1 SHALL be loaded as follows, in priority order:
- 0 if rs1_q=0;
- else wb_data if wb_we=1 and wb_addr=rs1_q in that cycle;
- else fwd1_data if fwd1_valid=1;
- else rd1.
op2 SHALL be loaded the same way.
REQ-017 A write with wb_addr=0 SHALL never be forwarded; operand index 0 SHALL always resolve to 0.
REQ-018 In HOLD with out_ready=0, a write with wb_we=1 and wb_addr=rs1_q≠0 SHALL update op1 with wb_data at that edge; op2 SHALL be handled the same way.
REQ-019 When rs1 equals rs2, both operands SHALL resolve identically.

Reset
REQ-020 With rst=1 at an edge, the FSM SHALL go to IDLE; out_valid, op1, op2, fwd1_valid, fwd2_valid, rs1_q and rs2_q SHALL be cleared to 0.
REQ-021 While rst=1, in_ready SHALL be 0 and no request SHALL be accepted.
REQ-022 Reset asserted in READ or HOLD SHALL abort the in-flight request with no output handshake; out_valid=0 from the next cycle.
REQ-023 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-024 Basic read: bank x5=0x1234, x6=0xABCD; request rs1=5, rs2=6 -> out_valid after 2 edges with op1=0x1234, op2=0xABCD.
REQ-025 Accept-edge bypass: at the accept edge, write wb_addr=5, wb_data=0x55 while the bank holds x5=0x11 -> op1=0x55.
REQ-026 READ-cycle bypass: the accept edge also writes x5=0x22, and the READ cycle writes x5=0x33 -> op1=0x33.
REQ-027 Zero register: rs1=0, rs2=0 with a concurrent write wb_addr=0, wb_data=0xFFFF -> op1=op2=0.
REQ-028 Backpressure plus update: out_ready=0 for 3 cycles; in HOLD write x6=0x77 with rs2=6 -> op2 becomes 0x77, op1 stays unchanged and out_valid stays 1.
REQ-029 Reset in READ: assert rst for one edge -> out_valid stays 0, in_ready=1 in the next cycle, and a new request completes normally.
